fetch_unit: RTL

- Parametrised instruction-fetch front end; successor to the free-running word-step PC.
- Generates byte-addressed sequential fetch requests (PC+4) to instruction memory over a valid/ready request channel with variable-latency in-order responses.
- Buffers returned instructions with their PC for the decode stage over a valid/ready channel.
- Supports branch/jump redirect with flush of buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef logic [INST_W-1:0] fetch_entry_t;

    // Counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with single-cycle flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (count_reg != CW'(DEPTH));
    // Zero the head while empty so the output never shows a stale word.
    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with credit-limited issue, in-order response
// buffering and redirect flush of buffered and in-flight words.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BUF_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc
);

    localparam int              CW   = cnt_w(BUF_DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] out_pc_reg, out_pc_next;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     in_use;
    logic            started_reg;
    logic            credit_ok;
    logic            req_fire;
    logic            inst_fire;
    logic            rsp_keep;
    logic            buf_empty;
    logic            unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Every accepted request owns a buffer slot, so responses never need backpressure.
    assign in_use    = {1'b0, outstanding_reg} + {1'b0, buf_count};
    assign credit_ok = (in_use < (CW+1)'(BUF_DEPTH));

    // started_reg holds issue off for the first cycle after reset.
    assign imem_req_valid = !rst && started_reg && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);
    assign inst_valid = !rst && !buf_empty;
    assign inst_fire  = inst_valid && inst_ready;
    assign inst_pc    = out_pc_reg;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (imem_rsp_data),
        .pop       (inst_fire),
        .head_data (inst_data),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_comb begin
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;
        fetch_pc_next    = fetch_pc_reg;
        out_pc_next      = out_pc_reg;

        case ({req_fire, imem_rsp_valid})
            2'b10:   outstanding_next = outstanding_reg + CW'(1);
            2'b01:   outstanding_next = outstanding_reg - CW'(1);
            default: outstanding_next = outstanding_reg;
        endcase

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_next = outstanding_next;
            fetch_pc_next = redirect_target;
            out_pc_next   = redirect_target;
        end else begin
            if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + STEP;
            end
            if (inst_fire) begin
                out_pc_next = out_pc_reg + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_VECTOR;
            out_pc_reg      <= RESET_VECTOR;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            started_reg     <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            out_pc_reg      <= out_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            started_reg     <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_reg != '0));

    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (imem_req_valid && !imem_req_ready) |=> (imem_req_valid || redirect_valid));
`endif

endmodule
